// File: rtl/matrix_result_writer.sv
// -----------------------------------------------------------------------------
// matrix_result_writer
//
// Responder side of the matrix-op result-write handshake. One request
// (id, shape, name) is accepted while idle. The writer then puts three
// metadata words at the start of that matrix's block of shared BRAM and
// streams rows*cols data words in behind them. A result that does not fit in
// the block after the header is rejected with a one-cycle write_error.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   write_request   producer requests a result write (held until write_ready)
//   write_ready     writer idle; a request is accepted on this clock edge
//   matrix_id       destination block
//   actual_rows     result rows
//   actual_cols     result columns
//   matrix_name     8 name bytes, element 0 is the first character
//   data_in         stream word, row-major
//   data_valid      data_in valid
//   writer_ready    writer is consuming stream words this cycle
//   write_done      one-cycle pulse, block fully written
//   write_error     one-cycle pulse, request rejected (too large)
//   bram_we         BRAM write enable
//   bram_addr       BRAM write address (0 when bram_we is low)
//   bram_wdata      BRAM write data    (0 when bram_we is low)
// -----------------------------------------------------------------------------
module matrix_result_writer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int BLOCK_SIZE     = 1024,
  parameter int METADATA_WORDS = 3,
  parameter int NUM_MATRICES   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            write_request,
  output logic                            write_ready,
  input  logic [$clog2(NUM_MATRICES)-1:0] matrix_id,
  input  logic [7:0]                      actual_rows,
  input  logic [7:0]                      actual_cols,
  input  logic [7:0]                      matrix_name [0:7],
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            data_valid,
  output logic                            writer_ready,
  output logic                            write_done,
  output logic                            write_error,
  output logic                            bram_we,
  output logic [ADDR_WIDTH-1:0]           bram_addr,
  output logic [DATA_WIDTH-1:0]           bram_wdata
);

  // Largest data payload that still fits behind the header in one block.
  localparam logic [15:0] CAPACITY = 16'(BLOCK_SIZE - METADATA_WORDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    META0  = 3'd1,
    META1  = 3'd2,
    META2  = 3'd3,
    STREAM = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [7:0]            rows_q, cols_q;
  logic [7:0]            name_q [0:7];
  logic [15:0]           count_q;
  logic [15:0]           idx_q;

  // Shape of the request currently on the inputs; only meaningful in IDLE.
  logic [15:0] count_in;
  assign count_in = 16'(actual_rows) * 16'(actual_cols);

  logic accept;
  assign accept = (state_q == IDLE) && write_request;

  // ---------------------------------------------------------------------------
  // State and captured request
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values; the combinational block below uses blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      // NOTE: name_q is an 8-byte register array, not a RAM, so resetting it
      // is cheap; the shared BRAM itself is never reset by this block.
      for (int i = 0; i < 8; i++) name_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Fields are sampled only here; later input changes are ignored.
        base_q  <= ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);
        rows_q  <= actual_rows;
        cols_q  <= actual_cols;
        count_q <= count_in;
        idx_q   <= '0;
        for (int i = 0; i < 8; i++) name_q[i] <= matrix_name[i];
      end else if (state_q == STREAM && data_valid) begin
        idx_q <= idx_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    write_ready  = 1'b0;
    writer_ready = 1'b0;
    write_done   = 1'b0;
    write_error  = 1'b0;
    bram_we      = 1'b0;
    bram_addr    = '0;
    bram_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        write_ready = 1'b1;
        if (write_request) state_d = (count_in > CAPACITY) ? ERR : META0;
      end
      META0: begin
        bram_we    = 1'b1;
        bram_addr  = base_q;
        bram_wdata = DATA_WIDTH'({rows_q, cols_q, 16'h0000});
        state_d    = META1;
      end
      META1: begin
        bram_we    = 1'b1;
        bram_addr  = base_q + ADDR_WIDTH'(1);
        bram_wdata = DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
        state_d    = META2;
      end
      META2: begin
        bram_we    = 1'b1;
        bram_addr  = base_q + ADDR_WIDTH'(2);
        bram_wdata = DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
        // An empty result is complete once the header is down.
        state_d    = (count_q == 16'd0) ? DONE : STREAM;
      end
      STREAM: begin
        writer_ready = 1'b1;
        if (data_valid) begin
          // Zero-latency pass-through: the word goes to BRAM in the cycle it is valid.
          bram_we    = 1'b1;
          bram_addr  = base_q + ADDR_WIDTH'(METADATA_WORDS) + ADDR_WIDTH'(idx_q);
          bram_wdata = data_in;
          if (idx_q == count_q - 16'd1) state_d = DONE;
        end
      end
      DONE: begin
        write_done = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        write_error = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_result_writer.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_writer
//
// Self-checking bench for matrix_result_writer. Every expected BRAM write is
// pushed to a scoreboard queue when a request is driven; a negedge monitor
// pops and compares each write the DUT makes, keeps a model of the BRAM and
// counts done/error pulses. Directed requests cover normal shapes, data_valid
// gaps, the empty matrix, the capacity limit, mid-stream reset and
// back-to-back requests.
// -----------------------------------------------------------------------------
module tb_matrix_result_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_request;
  logic        write_ready;
  logic [2:0]  matrix_id;
  logic [7:0]  actual_rows;
  logic [7:0]  actual_cols;
  logic [7:0]  matrix_name [0:7];
  logic [31:0] data_in;
  logic        data_valid;
  logic        writer_ready;
  logic        write_done;
  logic        write_error;
  logic        bram_we;
  logic [12:0] bram_addr;
  logic [31:0] bram_wdata;

  matrix_result_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_request(write_request),
    .write_ready  (write_ready),
    .matrix_id    (matrix_id),
    .actual_rows  (actual_rows),
    .actual_cols  (actual_cols),
    .matrix_name  (matrix_name),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .writer_ready (writer_ready),
    .write_done   (write_done),
    .write_error  (write_error),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_wdata   (bram_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb [$];
  logic [31:0] stim [$];
  logic [31:0] mem [0:8191];

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int done_cnt   = 0;
  int err_cnt    = 0;
  int wready_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (write_done)   done_cnt++;
    if (write_error)  err_cnt++;
    if (writer_ready) wready_cnt++;
    if (bram_we) begin
      mem[bram_addr] = bram_wdata;
      check("write_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("bram_addr", 64'(bram_addr), 64'(e.addr));
        check("bram_wdata", 64'(bram_wdata), 64'(e.data));
      end
    end else begin
      check("idle_bus_zero", {19'h0, bram_addr, bram_wdata}, 64'h0);
    end
  end

  task automatic set_name(input logic [63:0] name);
    for (int k = 0; k < 8; k++) matrix_name[k] = name[63-8*k -: 8];
  endtask

  task automatic fill(input int n);
    stim.delete();
    for (int k = 0; k < n; k++) stim.push_back($urandom);
  endtask

  task automatic sb_push(input logic [12:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_write_ready"}, 64'(write_ready), 64'd1);
    check({tag, "_other_outs"},
          64'({writer_ready, write_done, write_error, bram_we, bram_addr, bram_wdata}), 64'd0);
  endtask

  // One request. gap_at/gap_len: drop data_valid for gap_len writer_ready
  // cycles before word gap_at. junk: hold data_valid high with garbage while
  // the writer is not streaming. hold: keep write_request high after accept
  // (with scrambled fields) so the next call chains straight on.
  // abort_at: assert reset once that many words have been consumed.
  task automatic run_req(input logic [2:0] id, input logic [7:0] rows, input logic [7:0] cols,
                         input logic [63:0] name, input int gap_at, input int gap_len,
                         input bit junk, input bit hold, input int abort_at);
    int   count, i, gap_rem, acc, d0, e0, w0;
    bit   is_err, consumed;
    logic [12:0] base;
    count  = int'(rows) * int'(cols);
    is_err = count > 1021;
    base   = {id, 10'h000};

    if (write_request) check("chained_ready", 64'(write_ready), 64'd1);
    else begin
      @(posedge clk); #1;
    end
    matrix_id     = id;
    actual_rows   = rows;
    actual_cols   = cols;
    set_name(name);
    write_request = 1'b1;
    for (int n = 0; n < 100 && !write_ready; n++) begin
      @(posedge clk); #1;
    end
    check("accept_wait", 64'(write_ready), 64'd1);

    if (!is_err) begin
      sb_push(base, {rows, cols, 16'h0000});
      sb_push(base + 13'd1, name[63:32]);
      sb_push(base + 13'd2, name[31:0]);
      for (int k = 0; k < count; k++) sb_push(base + 13'd3 + 13'(k), stim[k]);
    end
    d0 = done_cnt; e0 = err_cnt; w0 = wready_cnt;

    @(posedge clk); #1;  // accept edge
    acc = cyc;
    if (hold) begin
      matrix_id   = ~id;
      actual_rows = 8'hFF;
      actual_cols = 8'hFF;
      set_name(64'hA5A5_A5A5_5A5A_5A5A);
    end else begin
      write_request = 1'b0;
    end

    i = 0;
    gap_rem = gap_len;
    for (int n = 0; n < 4000 && i < count && !is_err; n++) begin
      if (abort_at >= 0 && i == abort_at) break;
      consumed = 1'b0;
      if (writer_ready) begin
        if (i == gap_at && gap_rem > 0) begin
          data_valid = 1'b0;
          gap_rem--;
        end else begin
          data_valid = 1'b1;
          data_in    = stim[i];
          consumed   = 1'b1;
        end
      end else begin
        data_valid = junk;
        data_in    = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      if (consumed) i++;
    end
    data_valid = 1'b0;
    data_in    = '0;

    if (abort_at >= 0) begin
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      check("abort_pending_writes", 64'(sb.size()), 64'(count - abort_at));
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end

    for (int n = 0; n < 20 && !write_done && !write_error; n++) begin
      @(posedge clk); #1;
    end
    check("finish_wait", 64'(write_done | write_error), 64'd1);
    check("done_flag", 64'(write_done), 64'(!is_err));
    check("error_flag", 64'(write_error), 64'(is_err));
    // Latency counted with the accept edge as cycle 1: 3 header + count + 1.
    if (is_err) check("err_latency", 64'(cyc - acc + 1), 64'd1);
    else if (gap_len == 0) check("done_latency", 64'(cyc - acc + 1), 64'(4 + count));

    @(posedge clk); #1;
    check("pulse_one_cycle", 64'({write_done, write_error}), 64'd0);
    check("done_count", 64'(done_cnt - d0), 64'(!is_err));
    check("error_count", 64'(err_cnt - e0), 64'(is_err));
    check("writer_ready_cycles", 64'(wready_cnt - w0), is_err ? 64'd0 : 64'(count + gap_len));
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = 32'hFFFF_FFFF;
    rst_n         = 1'b0;
    write_request = 1'b0;
    matrix_id     = '0;
    actual_rows   = '0;
    actual_cols   = '0;
    set_name(64'h0);
    data_in       = '0;
    data_valid    = 1'b0;
    #12 check_reset_outputs("reset");
    #10 rst_n = 1'b1;

    // 1: 2x3 "TSR" into block 0, continuous valid.
    stim = '{32'd1, 32'd4, 32'd2, 32'd5, 32'd3, 32'd6};
    run_req(3'd0, 8'd2, 8'd3, {8'h54, 8'h53, 8'h52, 40'h0}, -1, 0, 1'b0, 1'b0, -1);
    check("t1_mem0", 64'(mem[0]), 64'h0203_0000);
    check("t1_mem1", 64'(mem[1]), 64'h5453_5200);
    check("t1_mem2", 64'(mem[2]), 64'h0);
    check("t1_mem3_8", {mem[3][7:0], mem[4][7:0], mem[5][7:0], mem[6][7:0], mem[7][7:0], mem[8][7:0]},
          64'h0000_0104_0205_0306);

    // 2: 3x1 into block 2 with a two-cycle gap between words 8 and 9.
    stim = '{32'd7, 32'd8, 32'd9};
    run_req(3'd2, 8'd3, 8'd1, 64'h4D41_5452_4958_3032, 2, 2, 1'b0, 1'b0, -1);
    check("t2_words", {mem[2051][15:0], mem[2052][15:0], mem[2053][15:0]}, 64'h0007_0008_0009);

    // 3: empty matrix, header only.
    stim.delete();
    run_req(3'd3, 8'd0, 8'd0, 64'h454D_5054_5900_0000, -1, 0, 1'b0, 1'b0, -1);
    check("t3_mem3072", 64'(mem[3072]), 64'h0);

    // 4: 32x32 exceeds capacity; 4x255 = 1020 just fits.
    run_req(3'd1, 8'd32, 8'd32, 64'h4249_4700_0000_0000, -1, 0, 1'b0, 1'b0, -1);
    fill(1020);
    run_req(3'd1, 8'd4, 8'd255, 64'h4649_5400_0000_0000, -1, 0, 1'b0, 1'b0, -1);

    // 5: reset after 2 of 6 words, then a full request to block 4.
    fill(6);
    run_req(3'd7, 8'd2, 8'd3, 64'h4142_4F52_5400_0000, -1, 0, 1'b0, 1'b0, 2);
    fill(6);
    run_req(3'd4, 8'd3, 8'd2, 64'h5245_5354_4152_5400, -1, 0, 1'b0, 1'b0, -1);

    // 6: back-to-back requests with junk data_valid outside STREAM.
    fill(4);
    run_req(3'd5, 8'd2, 8'd2, 64'h4649_5253_5400_0000, -1, 0, 1'b1, 1'b1, -1);
    fill(3);
    run_req(3'd6, 8'd1, 8'd3, 64'h5345_434F_4E44_0000, -1, 0, 1'b1, 1'b0, -1);

    repeat (3) @(posedge clk);
    #1 check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
